// File: rtl/booth_digit_mult.sv
// Radix-2 Booth digit consumer: accumulates mr * (sum of signed digits) one digit per clock,
// rebuilds the original multiplier from the nonzero flags and flags illegal digit codes.
module booth_digit_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   mr,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   z,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   md_dec,
  output logic               err,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Digit value: 0, +1 or -1; the illegal code (x=1,z=0) contributes nothing.
  function automatic logic signed [1:0] digit_val(input logic xd, input logic zd);
    if (!zd)
      return 2'sd0;
    else if (xd)
      return -2'sd1;
    else
      return 2'sd1;
  endfunction

  function automatic logic digit_illegal(input logic xd, input logic zd);
    return xd & ~zd;
  endfunction

  // Sign-extend the multiplicand to product width, then weight by 2^sh.
  function automatic logic signed [PW-1:0] weighted_mr(input logic signed [WIDTH-1:0] m,
                                                       input logic [CW-1:0] sh);
    logic signed [PW-1:0] ext;
    ext = PW'(m);
    return ext <<< sh;
  endfunction

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic signed [WIDTH-1:0] mr_q;
  logic [WIDTH-1:0]        x_q;
  logic [WIDTH-1:0]        z_q;
  logic signed [PW-1:0]    acc;
  logic [WIDTH-1:0]        md_q;
  logic                    par;
  logic                    err_q;

  logic signed [1:0]       digit;
  logic signed [PW-1:0]    term;
  logic                    bad;
  logic                    par_next;

  always_comb begin
    digit    = digit_val(x_q[cnt], z_q[cnt]);
    bad      = digit_illegal(x_q[cnt], z_q[cnt]);
    term     = weighted_mr(mr_q, cnt);
    par_next = par ^ z_q[cnt];
  end

  // Operand capture registers carry no reset; they are only read in RUN after a capture.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      mr_q <= mr;
      x_q  <= x;
      z_q  <= z;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      md_q  <= '0;
      par   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= '0;
            md_q  <= '0;
            par   <= 1'b0;
            err_q <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (digit == 2'sd1)
            acc <= acc + term;
          else if (digit == -2'sd1)
            acc <= acc - term;
          // md_dec bit i is the running parity of z[0..i].
          md_q[cnt] <= par_next;
          par       <= par_next;
          if (bad)
            err_q <= 1'b1;
          if (cnt == LAST_DIGIT) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign prod      = acc;
  assign md_dec    = md_q;
  assign err       = err_q;

endmodule

// File: tb/tb_booth_digit_mult.sv
// Randomized and directed bench for booth_digit_mult (WIDTH=4) against an arithmetic digit-sum model.
module tb_booth_digit_mult;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  mr, x, z;
  logic          in_valid, in_ready;
  logic [PW-1:0] prod;
  logic [W-1:0]  md_dec;
  logic          err, out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  booth_digit_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mr(mr), .x(x), .z(z),
    .in_valid(in_valid), .in_ready(in_ready),
    .prod(prod), .md_dec(md_dec), .err(err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: multiplier value is the plain sum of d_i*2^i, product is mr*value mod 2^(2W).
  task automatic model(input logic [W-1:0] m, input logic [W-1:0] xv, input logic [W-1:0] zv,
                       output logic [PW-1:0] e_prod, output logic [W-1:0] e_md,
                       output logic e_err);
    int sum;
    int p;
    logic parity;
    sum = 0; parity = 1'b0; e_err = 1'b0; e_md = '0;
    for (int i = 0; i < W; i++) begin
      if (zv[i]) sum += (xv[i] ? -1 : 1) * (1 << i);
      else if (xv[i]) e_err = 1'b1;
      parity   = parity ^ zv[i];
      e_md[i]  = parity;
    end
    p = $signed(m) * sum;
    e_prod = p[PW-1:0];
  endtask

  // Standard radix-2 Booth recoding of a multiplier value.
  task automatic booth_encode(input logic [W-1:0] md, output logic [W-1:0] xv,
                              output logic [W-1:0] zv);
    logic prev;
    for (int i = 0; i < W; i++) begin
      prev  = (i == 0) ? 1'b0 : md[i-1];
      zv[i] = md[i] ^ prev;
      xv[i] = md[i] & zv[i];
    end
  endtask

  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] xv, input logic [W-1:0] zv,
                        input int hold);
    logic [PW-1:0] e_prod;
    logic [W-1:0]  e_md;
    logic          e_err;
    int            k;
    model(m, xv, zv, e_prod, e_md, e_err);
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    mr = m; x = xv; z = zv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; mr = $urandom; x = $urandom; z = $urandom;
    k = 0;
    while (!out_valid && k < 20) begin
      if (in_ready) check("in_ready_run", 32'(in_ready), 32'd0);
      @(posedge clk); #1; k++;
    end
    if (!out_valid) check("timeout", 32'(out_valid), 32'd1);
    check("latency", 32'(k), 32'(W));
    check("prod", 32'(prod), 32'(e_prod));
    check("md_dec", 32'(md_dec), 32'(e_md));
    check("err", 32'(err), 32'(e_err));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; mr = $urandom; x = $urandom; z = $urandom;
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_prod", 32'(prod), 32'(e_prod));
      check("hold_md", 32'(md_dec), 32'(e_md));
      check("hold_err", 32'(err), 32'(e_err));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] md, xv, zv, m;
    rst = 1'b1; mr = '0; x = '0; z = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_prod", 32'(prod), 32'd0);
    check("rst_md", 32'(md_dec), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    run_op(4'h3, 4'b0101, 4'b1111, 0);
    check("case1_const", 32'(prod), 32'h0F);
    run_op(4'h8, 4'b1000, 4'b1000, 0);
    check("case2_const", 32'(prod), 32'h40);
    run_op(4'h7, 4'b0001, 4'b0001, 0);
    check("case3_const", 32'(prod), 32'hF9);
    run_op(4'h3, 4'b0010, 4'b0000, 0);
    check("case4_err", 32'(err), 32'd1);
    run_op(4'h3, 4'b0101, 4'b1111, 5);

    // Reset on the second RUN clock discards the operation.
    mr = 4'h3; x = 4'b0101; z = 4'b1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_prod", 32'(prod), 32'd0);
    check("midrst_md", 32'(md_dec), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    run_op(4'h8, 4'b1000, 4'b1000, 0);

    for (int t = 0; t < 60; t++) begin
      m = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        md = $urandom;
        booth_encode(md, xv, zv);
      end else begin
        xv = $urandom; zv = $urandom;
      end
      run_op(m, xv, zv, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1);
  end

endmodule
